// File: rtl/ocp_mem_slave.sv
//==============================================================================
// Module   : ocp_mem_slave
// Purpose  : OCP slave memory. It sits directly behind a fabric port and
//            serves one command at a time from a word-organised on-chip RAM.
//            Writes honour byte enables. A programmable number of wait
//            states is inserted between command accept and response.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters:
//   MEM_WORDS    number of 32-bit words (power of two, 16..65536)
//   WAIT_STATES  extra cycles between accept and response (0..15)
// Ports:
//   clk           clock
//   nrst          asynchronous active-low reset
//   i_MAddr       byte address (already decoded by the fabric port)
//   i_MCmd        OCP command: IDLE=0, WRITE=1, READ=2, others unsupported
//   i_MData       write data
//   i_MByteEn     write byte enables
//   o_SCmdAccept  command accept; high only while idle
//   o_SData       read data; non-zero only in the response cycle of a READ
//   o_SResp       OCP response: NULL=0, DVA=1, FAIL=2, ERR=3
// Build option:
//   OCP_MEM_RANGE_CHECK_EN  when defined, byte addresses >= MEM_WORDS*4 get
//                           an ERR response and never write the RAM. When
//                           undefined, addresses alias modulo MEM_WORDS*4.
//==============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif

module ocp_mem_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [`ADDR_WIDTH-1:0] i_MAddr,
  input  logic [2:0]             i_MCmd,
  input  logic [`DATA_WIDTH-1:0] i_MData,
  input  logic [`BEN_WIDTH-1:0]  i_MByteEn,
  output logic                   o_SCmdAccept,
  output logic [`DATA_WIDTH-1:0] o_SData,
  output logic [1:0]             o_SResp
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = 4;

  // One-hot state encoding
  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_WAIT = 3'b010;
  localparam logic [2:0] ST_RESP = 3'b100;

  localparam logic [2:0] CMD_IDLE  = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;

  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  localparam logic [CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [CNT_W-1:0]       wait_cnt;
  logic [CNT_W-1:0]       wait_cnt_nxt;

  logic [`ADDR_WIDTH-1:0] lat_addr;
  logic [2:0]             lat_cmd;
  logic [`DATA_WIDTH-1:0] lat_data;
  logic [`BEN_WIDTH-1:0]  lat_ben;

  logic [`DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                   in_idle;
  logic                   start;
  logic                   fire;
  logic [`ADDR_WIDTH-1:0] cur_addr;
  logic [2:0]             cur_cmd;
  logic [`DATA_WIDTH-1:0] cur_data;
  logic [`BEN_WIDTH-1:0]  cur_ben;
  logic [IDX_W-1:0]       word_idx;
  logic                   in_range;
  logic                   do_write;
  logic                   do_read;
  logic [1:0]             resp_val;

  assign in_idle      = (state == ST_IDLE);
  assign o_SCmdAccept = in_idle;
  assign start        = in_idle && (i_MCmd != CMD_IDLE);

  // With no wait states the RAM access happens on the same edge that
  // accepts the command, before the latch registers hold it, so the
  // access is steered from the live inputs while idle.
  assign cur_addr = in_idle ? i_MAddr   : lat_addr;
  assign cur_cmd  = in_idle ? i_MCmd    : lat_cmd;
  assign cur_data = in_idle ? i_MData   : lat_data;
  assign cur_ben  = in_idle ? i_MByteEn : lat_ben;

  // The edge entering RESP is where the transaction takes effect.
  assign fire = (start && (WAIT_STATES == 0)) ||
                ((state == ST_WAIT) && (wait_cnt == '0));

  assign word_idx = cur_addr[IDX_W+1:2];

`ifdef OCP_MEM_RANGE_CHECK_EN
  assign in_range = (cur_addr[`ADDR_WIDTH-1:IDX_W+2] == '0);
`else
  assign in_range = 1'b1;
`endif

  // Byte-lane bits and (without range checking) the upper bits take no
  // part in word selection.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cur_addr[1:0], cur_addr[`ADDR_WIDTH-1:IDX_W+2]};

  assign do_write = fire && in_range && (cur_cmd == CMD_WRITE);
  assign do_read  = fire && in_range && (cur_cmd == CMD_READ);

  always_comb begin
    resp_val = RESP_ERR;
    if (in_range && ((cur_cmd == CMD_READ) || (cur_cmd == CMD_WRITE))) begin
      resp_val = RESP_DVA;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (WAIT_STATES > 0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end else begin
            state_nxt = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = ST_RESP;
        end else begin
          wait_cnt_nxt = wait_cnt - 1'b1;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      lat_addr <= '0;
      lat_cmd  <= CMD_IDLE;
      lat_data <= '0;
      lat_ben  <= '0;
      o_SResp  <= RESP_NULL;
      o_SData  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (start) begin
        lat_addr <= i_MAddr;
        lat_cmd  <= i_MCmd;
        lat_data <= i_MData;
        lat_ben  <= i_MByteEn;
      end
      // Response registers are non-zero only for the single RESP cycle.
      o_SResp <= fire ? resp_val : RESP_NULL;
      o_SData <= do_read ? mem[word_idx] : '0;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < `BEN_WIDTH; b++) begin
        if (cur_ben[b]) begin
          mem[word_idx][b*8 +: 8] <= cur_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire
